// File: rtl/gf24_pow_engine.sv
// gf24_pow_engine: multi-lane GF(2^4) exponentiation (A^E) by left-to-right
// square-and-multiply, one exponent bit per clock, valid/ready on both sides.
// Field polynomial x^4 + x + 1. Optional macro GF_PHI_POSTMUL_EN adds a one-cycle
// POST state that multiplies every lane result by the constant PHI.
module gf24_pow_engine #(
    parameter int unsigned LANES = 4,
    parameter int unsigned EXP_W = 4,
    parameter logic [3:0]  PHI   = 4'hC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   in_data,
    input  logic [EXP_W-1:0]     in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   out_data,
    output logic                 busy
);

    localparam int unsigned DataW = 4 * LANES;
    localparam int unsigned CntW  = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
`ifdef GF_PHI_POSTMUL_EN
        ,
        StPost = 2'd3
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [DataW-1:0]  op_q, op_d;
    logic [DataW-1:0]  acc_q, acc_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DataW-1:0]  run_acc;

    // Squaring is linear over GF(2): fixed XOR network.
    function automatic logic [3:0] gf_sq(input logic [3:0] a);
        return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
    endfunction

    // Carry-less 4x4 product, then fold bits 6..4 back with x^4 = x + 1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ (7'(a) << i);
        end
        for (int i = 6; i >= 4; i--) begin
            if (p[i]) p = p ^ (7'b0010011 << (i - 4));
        end
        return p[3:0];
    endfunction

    // One square-and-multiply step per lane for the current exponent bit.
    always_comb begin
        run_acc = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            if (exp_q[cnt_q]) begin
                run_acc[4*l +: 4] = gf_mul(gf_sq(acc_q[4*l +: 4]), op_q[4*l +: 4]);
            end else begin
                run_acc[4*l +: 4] = gf_sq(acc_q[4*l +: 4]);
            end
        end
    end

`ifdef GF_PHI_POSTMUL_EN
    logic [DataW-1:0] post_acc;

    // Constant post-multiply by PHI, applied once after the last exponent bit.
    always_comb begin
        post_acc = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            post_acc[4*l +: 4] = gf_mul(acc_q[4*l +: 4], PHI);
        end
    end
`else
    logic unused_phi;
    assign unused_phi = ^PHI;
`endif

    // Next-state logic: accept in IDLE, walk exponent MSB->LSB in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = in_data;
                    exp_d = in_exp;
                    cnt_d = CntW'(EXP_W - 1);
                    for (int l = 0; l < int'(LANES); l++) acc_d[4*l +: 4] = 4'h1;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = run_acc;
                if (cnt_q == '0) begin
`ifdef GF_PHI_POSTMUL_EN
                    state_d = StPost;
`else
                    state_d = StDone;
`endif
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`ifdef GF_PHI_POSTMUL_EN
            StPost: begin
                acc_d   = post_acc;
                state_d = StDone;
            end
`endif
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            acc_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
`ifdef GF_PHI_POSTMUL_EN
    assign busy      = (state_q == StRun) || (state_q == StPost);
`else
    assign busy      = (state_q == StRun);
`endif
    assign out_data  = acc_q;

endmodule

// File: tb/tb_gf24_pow_engine.sv
// Scoreboard bench for gf24_pow_engine: driver pushes expected lane powers,
// a negedge monitor pops and compares on every output handshake.
module tb_gf24_pow_engine;

    localparam int unsigned LANES = 4;
    localparam int unsigned EXP_W = 4;
    localparam logic [3:0]  PHI   = 4'hC;
    localparam int unsigned DW    = 4 * LANES;
`ifdef GF_PHI_POSTMUL_EN
    localparam int unsigned LAT = EXP_W + 1;
`else
    localparam int unsigned LAT = EXP_W;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [EXP_W-1:0] in_exp;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb_q[$];
    bit rand_rdy = 0;

    gf24_pow_engine #(
        .LANES (LANES),
        .EXP_W (EXP_W),
        .PHI   (PHI)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by repeated doubling (x*alpha) and conditional add.
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] x;
        r = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return r;
    endfunction

    // Reference: a^e as e repeated multiplications (a^0 = 1, including a = 0).
    function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] d,
                                                 input logic [EXP_W-1:0] e);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            logic [3:0] p;
            p = 4'h1;
            for (int k = 0; k < int'(e); k++) p = ref_mul(p, d[4*l +: 4]);
`ifdef GF_PHI_POSTMUL_EN
            p = ref_mul(p, PHI);
`endif
            r[4*l +: 4] = p;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Monitor: every accepted result must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h, want no output", out_data);
            end else begin
                check("scoreboard", 32'(out_data), 32'(sb_q.pop_front()));
            end
        end
    end

    // Random backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [DW-1:0] d, input logic [EXP_W-1:0] e);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0, want 1");
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_exp   = e;
        sb_q.push_back(ref_result(d, e));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid=0, want 1");
        end
    endtask

    // Known answers for lane 0: {a, e, result}.
    logic [11:0] kat [6];

    initial begin
        int lat;
        int nbusy;
        int seen;
        logic [DW-1:0] d;
        logic [EXP_W-1:0] e;
        logic [DW-1:0] want;

`ifdef GF_PHI_POSTMUL_EN
        kat = '{12'h325, 12'h243, 12'h7F1, 12'h001, 12'h0E0, 12'h2E9};
        kat = '{12'h329, 12'h247, 12'h7FC, 12'h00C, 12'h0E0, 12'h2E6};
`else
        kat = '{12'h325, 12'h243, 12'h7F1, 12'h001, 12'h0E0, 12'h2E9};
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_exp    = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Four-lane inversion with latency and busy-length checks.
        issue(16'h1032, 4'hE);
        lat   = 0;
        nbusy = int'(busy);
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            nbusy += int'(busy);
        end
        check("latency", 32'(lat), 32'(LAT));
        check("busy_cycles", 32'(nbusy), 32'(LAT));
`ifndef GF_PHI_POSTMUL_EN
        check("inv4_data", 32'(out_data), 32'h10E9);
`endif
        @(posedge clk);
        #1;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);

        // Lane-0 known answers; other lanes random and covered by the scoreboard.
        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom);
            d[3:0] = kat[i][11:8];
            issue(d, EXP_W'(kat[i][7:4]));
            wait_valid(lat);
            check("kat_lane0", 32'(out_data[3:0]), 32'(kat[i][3:0]));
            @(posedge clk);
            #1;
        end

        // Backpressure: result held, input blocked, extra in_valid ignored.
        out_ready = 1'b0;
        d = DW'($urandom);
        e = EXP_W'($urandom);
        want = ref_result(d, e);
        issue(d, e);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = ~d;
            in_exp   = ~e;
            @(posedge clk);
            #1;
            check("bp_data", 32'(out_data), 32'(want));
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset two cycles into RUN discards the operation.
        issue(16'hBEEF, 4'hE);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            seen += int'(out_valid);
        end
        check("abort_no_result", 32'(seen), 32'd0);
        issue(16'h7352, 4'h3);
        wait_valid(lat);
        @(posedge clk);
        #1;

        // Randomized operands, exponents and backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) begin
            issue(DW'($urandom), EXP_W'($urandom));
        end
        lat = 0;
        while (sb_q.size() != 0 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        rand_rdy = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
